// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_pkg
// Brief  : Shared constants, state encoding and helpers for the display path.
// Rev    : 1.0
// ============================================================================
package display_pkg;

  localparam logic [3:0] MODE_DAY = 4'b0001;
  localparam logic [3:0] MODE_AVS = 4'b0010;
  localparam logic [3:0] MODE_TIM = 4'b0100;
  localparam logic [3:0] MODE_MAX = 4'b1000;

  localparam logic [3:0] BLANK = 4'hF;

  localparam int JOB_CYCLES   = 16;
  localparam int SHIFT_CYCLES = 14;
  localparam int BIN_W        = 14;

  localparam logic [BIN_W-1:0] CLAMP_2DIG = 14'd99;
  localparam logic [BIN_W-1:0] CLAMP_4DIG = 14'd9999;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_COMMIT = 3'd4
  } seq_state_t;

  function automatic logic [BIN_W-1:0] clamp_to(input logic [BIN_W-1:0] value,
                                                input logic [BIN_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  function automatic logic [3:0] blank_zero(input logic [3:0] digit);
    return (digit == 4'd0) ? BLANK : digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_serial.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_serial
// Brief  : 14-bit serial double-dabble converter producing four BCD digits.
// Rev    : 1.0
// ============================================================================
module bin2bcd_serial
  import display_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic [15:0]      bcd
);

  logic [BIN_W-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [3:0]       r_cnt;
  logic [15:0]      w_adj;
  logic [15:0]      w_next_bcd;
  logic             w_bcd_overflow_unused;

  // Add-3 correction on every digit that would overflow after the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Inputs are clamped to 9999, so the bit shifted out of the top never sets
  assign {w_bcd_overflow_unused, w_next_bcd} = {w_adj, r_bin[BIN_W-1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_bin <= value;
      r_bcd <= '0;
      r_cnt <= 4'(SHIFT_CYCLES);
    end else if (r_cnt != 4'd0) begin
      r_bcd <= w_next_bcd;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign bcd = r_bcd;

endmodule
`default_nettype wire

// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module : display_sequencer
// Brief  : Runs a per-mode list of BCD conversions and commits a whole frame.
// Rev    : 1.0
// ============================================================================
module display_sequencer
  import display_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        update,
  input  logic [3:0]  mode_sel,
  input  logic [6:0]  speed,
  input  logic [6:0]  max_speed,
  input  logic [9:0]  avg_speed,
  input  logic [13:0] distance,
  input  logic [18:0] HMS_time,
  output logic [3:0]  dig_u1,
  output logic [3:0]  dig_u0,
  output logic [3:0]  dig_l3,
  output logic [3:0]  dig_l2,
  output logic [3:0]  dig_l1,
  output logic [3:0]  dig_l0,
  output logic        point,
  output logic        col,
  output logic        busy,
  output logic        done
);

  seq_state_t r_state;
  logic       r_pending;
  logic [1:0] r_job;
  logic [3:0] r_cnt;

  logic [3:0]  r_mode;
  logic [6:0]  r_speed;
  logic [6:0]  r_max;
  logic [9:0]  r_avg;
  logic [13:0] r_dist;
  logic [6:0]  r_hours;
  logic [5:0]  r_minutes;

  logic [3:0] r_sh_u1, r_sh_u0, r_sh_l3, r_sh_l2, r_sh_l1, r_sh_l0;

  logic [BIN_W-1:0] w_conv_value;
  logic [15:0]      w_bcd;
  logic [3:0]       w_d3, w_d2, w_d1, w_d0;
  logic             w_last_job;
  logic             w_unused_seconds;

  assign w_unused_seconds = ^HMS_time[5:0];

  assign {w_d3, w_d2, w_d1, w_d0} = w_bcd;
  assign w_last_job = (r_mode == MODE_TIM) ? (r_job == 2'd2) : (r_job == 2'd1);
  assign busy       = (r_state != ST_IDLE);

  always_comb begin
    w_conv_value = clamp_to(14'(r_speed), CLAMP_2DIG);
    case (r_job)
      2'd1: begin
        case (r_mode)
          MODE_DAY: w_conv_value = clamp_to(r_dist, CLAMP_4DIG);
          MODE_AVS: w_conv_value = clamp_to(14'(r_avg), CLAMP_4DIG);
          MODE_MAX: w_conv_value = clamp_to(14'(r_max), CLAMP_2DIG);
          MODE_TIM: w_conv_value = 14'(r_minutes);
          default:  w_conv_value = '0;
        endcase
      end
      2'd2:    w_conv_value = clamp_to(14'(r_hours), CLAMP_2DIG);
      default: w_conv_value = clamp_to(14'(r_speed), CLAMP_2DIG);
    endcase
  end

  bin2bcd_serial u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (r_state == ST_LOAD),
    .value (w_conv_value),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_job     <= 2'd0;
      r_cnt     <= 4'd0;
      r_mode    <= 4'd0;
      r_speed   <= '0;
      r_max     <= '0;
      r_avg     <= '0;
      r_dist    <= '0;
      r_hours   <= '0;
      r_minutes <= '0;
      r_sh_u1   <= BLANK;
      r_sh_u0   <= BLANK;
      r_sh_l3   <= BLANK;
      r_sh_l2   <= BLANK;
      r_sh_l1   <= BLANK;
      r_sh_l0   <= BLANK;
      dig_u1    <= BLANK;
      dig_u0    <= BLANK;
      dig_l3    <= BLANK;
      dig_l2    <= BLANK;
      dig_l1    <= BLANK;
      dig_l0    <= BLANK;
      point     <= 1'b0;
      col       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Requests arriving mid-sequence collapse into one follow-on run
      if (update) r_pending <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (update || r_pending) begin
            r_state   <= ST_LOAD;
            r_pending <= 1'b0;
            r_job     <= 2'd0;
            r_mode    <= mode_sel;
            r_speed   <= speed;
            r_max     <= max_speed;
            r_avg     <= avg_speed;
            r_dist    <= distance;
            r_hours   <= HMS_time[18:12];
            r_minutes <= HMS_time[11:6];
          end
        end
        ST_LOAD: begin
          r_state <= ST_SHIFT;
          r_cnt   <= 4'(SHIFT_CYCLES - 1);
        end
        ST_SHIFT: begin
          if (r_cnt == 4'd0) r_state <= ST_WRITE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_WRITE: begin
          if (r_job == 2'd0) begin
            r_sh_u1 <= blank_zero(w_d1);
            r_sh_u0 <= w_d0;
          end else if (r_job == 2'd2) begin
            r_sh_l3 <= w_d1;
            r_sh_l2 <= w_d0;
          end else begin
            case (r_mode)
              MODE_DAY, MODE_AVS: begin
                // Leading zeros blank down to the tens digit so "0.0" stays visible
                r_sh_l3 <= blank_zero(w_d3);
                r_sh_l2 <= (w_d3 == 4'd0) ? blank_zero(w_d2) : w_d2;
                r_sh_l1 <= w_d1;
                r_sh_l0 <= w_d0;
              end
              MODE_MAX: begin
                r_sh_l3 <= BLANK;
                r_sh_l2 <= BLANK;
                r_sh_l1 <= blank_zero(w_d1);
                r_sh_l0 <= w_d0;
              end
              MODE_TIM: begin
                r_sh_l1 <= w_d1;
                r_sh_l0 <= w_d0;
              end
              default: begin
                r_sh_l3 <= BLANK;
                r_sh_l2 <= BLANK;
                r_sh_l1 <= BLANK;
                r_sh_l0 <= BLANK;
              end
            endcase
          end
          if (w_last_job) begin
            r_state <= ST_COMMIT;
          end else begin
            r_job   <= r_job + 2'd1;
            r_state <= ST_LOAD;
          end
        end
        ST_COMMIT: begin
          dig_u1  <= r_sh_u1;
          dig_u0  <= r_sh_u0;
          dig_l3  <= r_sh_l3;
          dig_l2  <= r_sh_l2;
          dig_l1  <= r_sh_l1;
          dig_l0  <= r_sh_l0;
          point   <= (r_mode == MODE_DAY) || (r_mode == MODE_AVS);
          col     <= (r_mode == MODE_TIM);
          done    <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_display_sequencer
// Brief  : Scoreboard bench for display_sequencer frames, timing and control.
// Rev    : 1.0
// ============================================================================
module tb_display_sequencer;
  import display_pkg::*;

  typedef struct packed {
    logic [3:0] u1, u0, l3, l2, l1, l0;
    logic       point, col;
  } frame_t;

  typedef struct {
    frame_t f;
    int     cyc;
  } exp_t;

  localparam frame_t BLANK_FRAME = '{u1: BLANK, u0: BLANK, l3: BLANK, l2: BLANK,
                                     l1: BLANK, l0: BLANK, point: 1'b0, col: 1'b0};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [3:0]  mode_sel = MODE_DAY;
  logic [6:0]  speed = '0;
  logic [6:0]  max_speed = '0;
  logic [9:0]  avg_speed = '0;
  logic [13:0] distance = '0;
  logic [18:0] HMS_time = '0;
  logic [3:0]  dig_u1, dig_u0, dig_l3, dig_l2, dig_l1, dig_l0;
  logic        point, col, busy, done;
  frame_t      dut_frame;

  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     n_done = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  frame_t held = BLANK_FRAME;
  logic   was_done = 1'b0;

  display_sequencer dut (
    .clock(clock), .reset(reset), .update(update), .mode_sel(mode_sel),
    .speed(speed), .max_speed(max_speed), .avg_speed(avg_speed),
    .distance(distance), .HMS_time(HMS_time),
    .dig_u1(dig_u1), .dig_u0(dig_u0), .dig_l3(dig_l3), .dig_l2(dig_l2),
    .dig_l1(dig_l1), .dig_l0(dig_l0), .point(point), .col(col),
    .busy(busy), .done(done)
  );

  assign dut_frame = {dig_u1, dig_u0, dig_l3, dig_l2, dig_l1, dig_l0, point, col};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic frame_t model(input logic [3:0] m, input int sp, input int mx,
                                   input int av, input int ds, input int hr, input int mi);
    frame_t f;
    int v;
    f = BLANK_FRAME;
    v = (sp > 99) ? 99 : sp;
    f.u1 = (v < 10) ? BLANK : 4'(v / 10);
    f.u0 = 4'(v % 10);
    case (m)
      MODE_DAY, MODE_AVS: begin
        v = (m == MODE_DAY) ? ds : av;
        if (v > 9999) v = 9999;
        f.l3 = (v < 1000) ? BLANK : 4'(v / 1000);
        f.l2 = (v < 100) ? BLANK : 4'((v / 100) % 10);
        f.l1 = 4'((v / 10) % 10);
        f.l0 = 4'(v % 10);
        f.point = 1'b1;
      end
      MODE_MAX: begin
        v = (mx > 99) ? 99 : mx;
        f.l1 = (v < 10) ? BLANK : 4'(v / 10);
        f.l0 = 4'(v % 10);
      end
      MODE_TIM: begin
        v = (hr > 99) ? 99 : hr;
        f.l3 = 4'(v / 10);
        f.l2 = 4'(v % 10);
        f.l1 = 4'(mi / 10);
        f.l0 = 4'(mi % 10);
        f.col = 1'b1;
      end
      default: ;
    endcase
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one update request and records the frame it must produce
  task automatic start_seq(input logic [3:0] m, input int sp, input int mx,
                           input int av, input int ds, input int hr, input int mi);
    exp_t e;
    mode_sel  = m;
    speed     = 7'(sp);
    max_speed = 7'(mx);
    avg_speed = 10'(av);
    distance  = 14'(ds);
    HMS_time  = {7'(hr), 6'(mi), 6'($urandom_range(0, 59))};
    update    = 1'b1;
    e.f   = model(m, sp, mx, av, ds, hr, mi);
    e.cyc = cyc + 2 + JOB_CYCLES * ((m == MODE_TIM) ? 3 : 2);
    sb.push_back(e);
    step(1);
    update    = 1'b0;
    mode_sel  = 4'($urandom);
    speed     = 7'($urandom);
    max_speed = 7'($urandom);
    avg_speed = 10'($urandom);
    distance  = 14'($urandom);
    HMS_time  = 19'($urandom);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 300) begin
      step(1);
      b++;
    end
    check("drain", sb.size(), 0);
    step(2);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      held     = BLANK_FRAME;
      was_done = 1'b0;
    end else begin
      if (was_done) check("done_width", done, 1'b0);
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("frame", dut_frame, mon_e.f);
          check("done_cycle", cyc, mon_e.cyc);
          held = mon_e.f;
        end
      end else begin
        check("hold", dut_frame, held);
      end
      was_done = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int idx;
    step(3);
    check("rst_frame", dut_frame, BLANK_FRAME);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    step(2);

    start_seq(MODE_DAY, 27, 0, 0, 1234, 0, 0);
    check("busy_running", busy, 1'b1);
    drain();
    check("day_const", dut_frame, {4'd2, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0});

    start_seq(MODE_TIM, 0, 0, 0, 0, 5, 7);
    drain();
    check("tim_const", dut_frame, {BLANK, 4'd0, 4'd0, 4'd5, 4'd0, 4'd7, 1'b0, 1'b1});

    start_seq(MODE_AVS, 5, 0, 45, 0, 0, 0);
    drain();
    check("avs_const", dut_frame, {BLANK, 4'd5, BLANK, BLANK, 4'd4, 4'd5, 1'b1, 1'b0});

    start_seq(MODE_DAY, 120, 0, 0, 16383, 0, 0);
    drain();
    check("day_clamp", dut_frame, {4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0});

    start_seq(MODE_MAX, 0, 0, 0, 0, 0, 0);
    drain();
    check("max_zero", dut_frame, {BLANK, 4'd0, BLANK, BLANK, BLANK, 4'd0, 1'b0, 1'b0});

    start_seq(MODE_DAY, 10, 0, 0, 0, 0, 0);
    drain();
    start_seq(MODE_MAX, 99, 127, 0, 0, 0, 0);
    drain();
    start_seq(MODE_TIM, 9, 0, 0, 0, 127, 59);
    drain();
    start_seq(MODE_AVS, 0, 0, 1023, 0, 0, 0);
    drain();

    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(0, 3);
      start_seq(4'(1 << idx), $urandom_range(0, 127), $urandom_range(0, 127),
                $urandom_range(0, 1023), $urandom_range(0, 16383),
                $urandom_range(0, 127), $urandom_range(0, 63));
      drain();
    end

    // Two requests and a mode change while busy: one extra run in the new mode
    n0 = n_done;
    start_seq(MODE_DAY, 33, 0, 0, 250, 0, 0);
    step(4);
    mode_sel = MODE_TIM;
    speed    = 7'd12;
    HMS_time = {7'd23, 6'd45, 6'd30};
    update   = 1'b1;
    step(1);
    update   = 1'b0;
    step(8);
    update   = 1'b1;
    step(1);
    update   = 1'b0;
    begin
      exp_t e2;
      e2.f   = model(MODE_TIM, 12, 0, 0, 0, 23, 45);
      e2.cyc = sb[sb.size()-1].cyc + 2 + 3 * JOB_CYCLES;
      sb.push_back(e2);
    end
    drain();
    step(60);
    check("pending_done_count", n_done - n0, 2);

    // Reset partway through a sequence
    start_seq(MODE_DAY, 50, 0, 0, 777, 0, 0);
    step(9);
    reset = 1'b1;
    sb.delete();
    step(1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_frame", dut_frame, BLANK_FRAME);
    check("midrst_done", done, 1'b0);
    reset = 1'b0;
    step(40);
    start_seq(MODE_MAX, 64, 42, 0, 0, 0, 0);
    drain();

    // Update coincident with reset is ignored
    mode_sel = MODE_DAY;
    reset    = 1'b1;
    update   = 1'b1;
    step(1);
    reset    = 1'b0;
    update   = 1'b0;
    check("coincident_busy", busy, 1'b0);
    check("coincident_frame", dut_frame, BLANK_FRAME);
    step(50);
    check("coincident_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
